// File: rtl/data_write_buffer_if.sv
// CPU-side and memory-side bundles for data_write_buffer.
// The CPU masters dwb_cpu_if; the buffer masters dwb_mem_if.
interface dwb_cpu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cpuAddr;
    logic [DATA_WIDTH-1:0] cpuWrData;
    logic                  cpuMemWrite;
    logic                  cpuMemRead;
    logic [DATA_WIDTH-1:0] cpuRdData;
    logic                  cpuStall;

    modport master (output cpuAddr, cpuWrData, cpuMemWrite, cpuMemRead,
                    input  cpuRdData, cpuStall);
    modport slave  (input  cpuAddr, cpuWrData, cpuMemWrite, cpuMemRead,
                    output cpuRdData, cpuStall);
endinterface

interface dwb_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWrData;
    logic                  memAck;
    logic [DATA_WIDTH-1:0] memRdData;

    modport master (output memReq, memWe, memAddr, memWrData,
                    input  memAck, memRdData);
    modport slave  (input  memReq, memWe, memAddr, memWrData,
                    output memAck, memRdData);
endinterface

// File: rtl/data_write_buffer.sv
// Posted-store write buffer between the CPU MEM-stage data port and a handshaked data memory.
// Optional store-to-load forwarding is enabled by defining DATA_WRITE_BUFFER_STORE_FORWARD_EN.
module data_write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic      clk,
    input  logic      rst,
    dwb_cpu_if.slave  cpu,
    dwb_mem_if.master mem
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RD_DONE} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q, rd_data_q;

    logic                  full, load_req, push, pop, stall;
    logic                  fwd_hit, drain_first;
    logic [DATA_WIDTH-1:0] fwd_data;

    assign full     = (count_q == CW'(DEPTH));
    // A simultaneous store wins; the load half of an illegal request is dropped.
    assign load_req = cpu.cpuMemRead & ~cpu.cpuMemWrite;

`ifdef DATA_WRITE_BUFFER_STORE_FORWARD_EN
    // Scan oldest to youngest so the last match is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (fifo_addr_q[head_q + PW'(i)] == cpu.cpuAddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[head_q + PW'(i)];
            end
        end
    end
    assign drain_first = 1'b0;
`else
    assign fwd_hit     = 1'b0;
    assign fwd_data    = '0;
    assign drain_first = (count_q != '0);
`endif

    // Stall is a function of occupancy and FSM state only, never of memAck.
    assign stall = ~rst & ((full & cpu.cpuMemWrite) |
                           (load_req & ~fwd_hit & (state_q != RD_DONE)));
    assign push  = cpu.cpuMemWrite & ~stall;
    assign pop   = (state_q == WR_BUSY) & mem.memAck;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[tail_q] <= cpu.cpuAddr;
            fifo_data_q[tail_q] <= cpu.cpuWrData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_req && !fwd_hit && !drain_first) begin
                        state_q    <= RD_BUSY;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= cpu.cpuAddr;
                    end else if (count_q != '0) begin
                        state_q     <= WR_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= fifo_addr_q[head_q];
                        mem_wdata_q <= fifo_data_q[head_q];
                    end
                end
                WR_BUSY: begin
                    if (mem.memAck) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                RD_BUSY: begin
                    if (mem.memAck) begin
                        state_q   <= RD_DONE;
                        mem_req_q <= 1'b0;
                        rd_data_q <= mem.memRdData;
                    end
                end
                RD_DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A forwarded load leaves its value behind so cpuRdData keeps holding it.
            if (load_req && fwd_hit)
                rd_data_q <= fwd_data;
        end
    end

    assign cpu.cpuStall    = stall;
    assign cpu.cpuRdData   = (load_req && fwd_hit) ? fwd_data : rd_data_q;
    assign mem.memReq      = mem_req_q;
    assign mem.memWe       = mem_we_q;
    assign mem.memAddr     = mem_addr_q;
    assign mem.memWrData   = mem_wdata_q;

    illegal_rw_a: assert property (@(posedge clk) disable iff (rst)
                                   !(cpu.cpuMemRead && cpu.cpuMemWrite));

endmodule
